restoring_divider: RTL and testbench

Parametrised sequential restoring divider, WIDTH bits wide. It supports signed and unsigned operation, detects divide-by-zero, and uses valid/ready handshakes on both input and output. It is the next-generation divider for the arithmetic units: one quotient bit per cycle, with operands captured on acceptance and results held until the consumer takes them.

---
 rtl/divider_pkg.sv | 23 ++
 rtl/restoring_divider_if.sv | 25 ++
 rtl/restoring_div_step.sv | 29 ++
 rtl/restoring_divider.sv | 138 +++++++++++++
 tb/tb_restoring_divider.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIXUP,
        DONE
    } div_state_e;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t twos_neg(word_t x);
        return ~x + word_t'(1);
    endfunction

    // Callers zero-extend into word_t and truncate back to their own width.
    function automatic word_t cond_neg(word_t x, logic en);
        return en ? twos_neg(x) : x;
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Operand and result handshake bundle for restoring_divider.
interface restoring_divider_if #(
    parameter int WIDTH = 16
);
    logic             src_valid;
    logic             src_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             dest_valid;
    logic             dest_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output src_valid, is_signed, dividend, divisor, dest_ready,
        input  src_ready, dest_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  src_valid, is_signed, dividend, divisor, dest_ready,
        output src_ready, dest_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift {A,Q}, trial subtract, restore.
module restoring_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] t;
    logic           unused_a_msb;

    // A stays below M, so its top bit is always clear before the shift.
    assign unused_a_msb = a_i[WIDTH];

    always_comb begin
        sh = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
        t  = sh - {1'b0, m_i};
        if (!t[WIDTH]) begin
            a_o = t;
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            a_o = sh;
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/restoring_divider.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle,
// valid/ready on both sides, divide-by-zero detection.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef logic [CW-1:0] cnt_t;

    div_state_e       state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [WIDTH:0]   a_q, a_d, a_step;
    logic [WIDTH-1:0] q_q, q_d, q_step;
    logic [WIDTH-1:0] m_q, m_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             srdy_q, srdy_d;
    logic             dvld_q, dvld_d;
    logic             neg_a, neg_b;

    restoring_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a_i(a_q),
        .q_i(q_q),
        .m_i(m_q),
        .a_o(a_step),
        .q_o(q_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        srdy_d  = srdy_q;
        dvld_d  = dvld_q;
        neg_a   = bus.is_signed & bus.dividend[WIDTH-1];
        neg_b   = bus.is_signed & bus.divisor[WIDTH-1];
        unique case (state_q)
            IDLE: begin
                if (bus.src_valid) begin
                    q_d    = WIDTH'(cond_neg(word_t'(bus.dividend), neg_a));
                    m_d    = WIDTH'(cond_neg(word_t'(bus.divisor), neg_b));
                    sq_d   = neg_a ^ neg_b;
                    sr_d   = neg_a;
                    a_d    = '0;
                    cnt_d  = '0;
                    srdy_d = 1'b0;
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        dvld_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_q + cnt_t'(1);
                if (cnt_q == cnt_t'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quo_d   = WIDTH'(cond_neg(word_t'(q_q), sq_q));
                rem_d   = WIDTH'(cond_neg(word_t'(a_q[WIDTH-1:0]), sr_q));
                dbz_d   = 1'b0;
                dvld_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.dest_ready) begin
                    dvld_d  = 1'b0;
                    srdy_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            srdy_q  <= 1'b1;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            srdy_q  <= srdy_d;
            dvld_q  <= dvld_d;
        end
    end

    assign bus.src_ready   = srdy_q;
    assign bus.dest_valid  = dvld_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed and model-checked bench for restoring_divider at WIDTH 16, 8, 32.
module tb_restoring_divider;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    restoring_divider_if #(.WIDTH(16)) i16 ();
    restoring_divider_if #(.WIDTH(8))  i8 ();
    restoring_divider_if #(.WIDTH(32)) i32 ();

    restoring_divider #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));
    restoring_divider #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
    restoring_divider #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic void ref_div(input int w, input logic s,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r);
        longint      sa, sb;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if ((b & mask) == 64'd0) begin
            q = mask;
            r = a & mask;
        end else if (s) begin
            sa = longint'(a << (64 - w)) >>> (64 - w);
            sb = longint'(b << (64 - w)) >>> (64 - w);
            q  = 64'(sa / sb) & mask;
            r  = 64'(sa % sb) & mask;
        end else begin
            q = (a & mask) / (b & mask);
            r = (a & mask) % (b & mask);
        end
    endfunction

    task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input int elat, input string nm,
                         input bit take);
        int lat;
        @(negedge clk);
        i16.src_valid = 1'b1;
        i16.is_signed = s;
        i16.dividend  = a;
        i16.divisor   = b;
        @(negedge clk);
        i16.src_valid = 1'b0;
        i16.dividend  = ~a;
        i16.divisor   = b ^ 16'h5a5a;
        lat = 1;
        while (i16.dest_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== elat) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", nm, lat, elat);
        end
        total++;
        if (i16.quotient !== eq) begin
            bad++;
            $display("FAIL %s quotient got=%h want=%h", nm, i16.quotient, eq);
        end
        total++;
        if (i16.remainder !== er) begin
            bad++;
            $display("FAIL %s remainder got=%h want=%h", nm, i16.remainder, er);
        end
        total++;
        if (i16.div_by_zero !== edbz) begin
            bad++;
            $display("FAIL %s div_by_zero got=%b want=%b", nm, i16.div_by_zero, edbz);
        end
        if (take) begin
            i16.dest_ready = 1'b1;
            @(negedge clk);
            i16.dest_ready = 1'b0;
        end
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] eq, er;
        int          lat;
        ref_div(8, s, 64'(a), 64'(b), eq, er);
        @(negedge clk);
        i8.src_valid = 1'b1;
        i8.is_signed = s;
        i8.dividend  = a;
        i8.divisor   = b;
        @(negedge clk);
        i8.src_valid = 1'b0;
        lat = 1;
        while (i8.dest_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (i8.quotient !== eq[7:0] || i8.remainder !== er[7:0] ||
            i8.div_by_zero !== (b == 8'd0) || lat != ((b == 8'd0) ? 1 : 10)) begin
            bad++;
            $display("FAIL w8 s=%b %h/%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h",
                     s, a, b, i8.quotient, i8.remainder, i8.div_by_zero, lat,
                     eq[7:0], er[7:0]);
        end
        i8.dest_ready = 1'b1;
        @(negedge clk);
        i8.dest_ready = 1'b0;
    endtask

    task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] eq, er;
        int          lat;
        ref_div(32, s, 64'(a), 64'(b), eq, er);
        @(negedge clk);
        i32.src_valid = 1'b1;
        i32.is_signed = s;
        i32.dividend  = a;
        i32.divisor   = b;
        @(negedge clk);
        i32.src_valid = 1'b0;
        lat = 1;
        while (i32.dest_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (i32.quotient !== eq[31:0] || i32.remainder !== er[31:0] ||
            i32.div_by_zero !== (b == 32'd0) || lat != ((b == 32'd0) ? 1 : 34)) begin
            bad++;
            $display("FAIL w32 s=%b %h/%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h",
                     s, a, b, i32.quotient, i32.remainder, i32.div_by_zero, lat,
                     eq[31:0], er[31:0]);
        end
        i32.dest_ready = 1'b1;
        @(negedge clk);
        i32.dest_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (i16.src_ready !== 1'b1 || i16.dest_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs got rdy=%b vld=%b want 1 0", i16.src_ready, i16.dest_valid);
        end
        total++;
        if (i16.quotient !== 16'h0 || i16.remainder !== 16'h0 || i16.div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got q=%h r=%h z=%b want 0 0 0",
                     i16.quotient, i16.remainder, i16.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        run16(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18, "u100_7", 1'b1);
        run16(1'b0, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 18, "u5_9", 1'b1);
    endtask

    task automatic test_signed();
        run16(1'b1, 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 18, "s-7_2", 1'b1);
        run16(1'b1, 16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 18, "s7_-2", 1'b1);
        run16(1'b1, 16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 18, "s-100_-7", 1'b1);
    endtask

    task automatic test_div_zero();
        run16(1'b0, 16'h1234, 16'h0, 16'hFFFF, 16'h1234, 1'b1, 1, "dz_u", 1'b1);
        run16(1'b1, 16'h8001, 16'h0, 16'hFFFF, 16'h8001, 1'b1, 1, "dz_s", 1'b1);
        run16(1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 18, "dz_clear", 1'b1);
    endtask

    task automatic test_extremes();
        run16(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0, 1'b0, 18, "s_ovf", 1'b1);
        run16(1'b1, 16'h8000, 16'd2, 16'hC000, 16'h0, 1'b0, 18, "s_min_2", 1'b1);
        run16(1'b0, 16'hFFFF, 16'd1, 16'hFFFF, 16'h0, 1'b0, 18, "u_max_1", 1'b1);
        run16(1'b0, 16'h8000, 16'hFFFF, 16'h0, 16'h8000, 1'b0, 18, "u_big_div", 1'b1);
    endtask

    task automatic test_backpressure();
        run16(1'b0, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 18, "bp", 1'b0);
        for (int i = 0; i < 10; i++) begin
            i16.src_valid = 1'b1;
            i16.is_signed = 1'b0;
            i16.dividend  = 16'd77 + 16'(i);
            i16.divisor   = 16'd7;
            @(negedge clk);
            total++;
            if (i16.quotient !== 16'd10 || i16.remainder !== 16'd0 ||
                i16.dest_valid !== 1'b1 || i16.src_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got q=%h r=%h vld=%b rdy=%b want 000a 0000 1 0",
                         i, i16.quotient, i16.remainder, i16.dest_valid, i16.src_ready);
            end
        end
        i16.src_valid  = 1'b0;
        i16.dest_ready = 1'b1;
        @(negedge clk);
        i16.dest_ready = 1'b0;
        total++;
        if (i16.src_ready !== 1'b1 || i16.dest_valid !== 1'b0 || i16.quotient !== 16'd10) begin
            bad++;
            $display("FAIL bp_release got rdy=%b vld=%b q=%h want 1 0 000a",
                     i16.src_ready, i16.dest_valid, i16.quotient);
        end
        repeat (3) @(negedge clk);
        total++;
        if (i16.dest_valid !== 1'b0 || i16.quotient !== 16'd10) begin
            bad++;
            $display("FAIL idle_hold got vld=%b q=%h want 0 000a", i16.dest_valid, i16.quotient);
        end
    endtask

    task automatic test_back_to_back();
        i16.dest_ready = 1'b1;
        run16(1'b0, 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 18, "b2b_a", 1'b0);
        @(negedge clk);
        total++;
        if (i16.dest_valid !== 1'b0 || i16.src_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pulse got vld=%b rdy=%b want 0 1", i16.dest_valid, i16.src_ready);
        end
        run16(1'b1, 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 18, "b2b_b", 1'b0);
        i16.dest_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        i16.src_valid = 1'b1;
        i16.is_signed = 1'b0;
        i16.dividend  = 16'd1000;
        i16.divisor   = 16'd3;
        @(negedge clk);
        i16.src_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (i16.src_ready !== 1'b1 || i16.dest_valid !== 1'b0 || i16.quotient !== 16'h0 ||
            i16.remainder !== 16'h0 || i16.div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst got rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0 0 0",
                     i16.src_ready, i16.dest_valid, i16.quotient, i16.remainder,
                     i16.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b1;
        run16(1'b0, 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 18, "after_rst", 1'b1);
    endtask

    task automatic test_width8();
        run8(1'b1, 8'h80, 8'hFF);
        run8(1'b0, 8'hFF, 8'h01);
        run8(1'b1, 8'hF9, 8'h02);
        run8(1'b0, 8'h5A, 8'h00);
        for (int i = 0; i < 24; i++) begin
            run8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_width32();
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run32(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        run32(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        run32(1'b1, 32'hDEAD_BEEF, 32'h0);
        for (int i = 0; i < 24; i++) begin
            run32(1'($urandom_range(0, 1)), $urandom,
                  (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
        end
    endtask

    initial begin
        i16.src_valid = 1'b0; i16.is_signed = 1'b0; i16.dividend = '0;
        i16.divisor = '0; i16.dest_ready = 1'b0;
        i8.src_valid = 1'b0; i8.is_signed = 1'b0; i8.dividend = '0;
        i8.divisor = '0; i8.dest_ready = 1'b0;
        i32.src_valid = 1'b0; i32.is_signed = 1'b0; i32.dividend = '0;
        i32.divisor = '0; i32.dest_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_width8();
        test_width32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
